// File: rtl/svdb_reg_pkg.sv
// rtl/svdb_reg_pkg.sv - shared types, widths and size-to-mask helper for the svdb register bank
package svdb_reg_pkg;

    localparam int REG_ADDR_W = 16;
    localparam int REG_DATA_W = 32;
    localparam int REG_SIZE_W = $clog2(REG_DATA_W) + 1;

    typedef enum logic [1:0] {
        ACC_RO  = 2'd0,
        ACC_RW  = 2'd1,
        ACC_WO  = 2'd2,
        ACC_W1C = 2'd3
    } access_e;

    typedef enum logic {
        LOAD   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    // One stored row of the register table; the mask is precomputed at load time
    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_SIZE_W-1:0] size;
        access_e               access;
        logic [REG_DATA_W-1:0] mask;
    } reg_desc_t;

    // Low `size` bits set; sizes at or above the data width give all ones
    function automatic logic [REG_DATA_W-1:0] size_to_mask(input logic [REG_SIZE_W-1:0] size);
        logic [REG_DATA_W-1:0] m;
        for (int i = 0; i < REG_DATA_W; i++) begin
            m[i] = (i < int'(size));
        end
        return m;
    endfunction

endpackage

// File: rtl/svdb_reg_match.sv
// rtl/svdb_reg_match.sv - parallel address comparator returning hit flag and lowest matching index
module svdb_reg_match #(
    parameter int N      = 16,
    parameter int ADDR_W = 16,
    parameter int IDX_W  = (N > 1) ? $clog2(N) : 1
) (
    input  logic [ADDR_W-1:0]         key_i,
    input  logic [N-1:0][ADDR_W-1:0]  entry_addr_i,
    input  logic [N-1:0]              entry_vld_i,
    output logic                      hit_o,
    output logic [IDX_W-1:0]          idx_o
);

    // Scan from the top so the lowest matching valid entry wins
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (entry_vld_i[i] && (entry_addr_i[i] == key_i)) begin
                hit_o = 1'b1;
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/svdb_reg_bank.sv
// rtl/svdb_reg_bank.sv - descriptor-loaded register bank with single-beat bus; SVDB_REG_HW_SET_EN adds a hardware W1C set port
module svdb_reg_bank
    import svdb_reg_pkg::*;
#(
    parameter int N_REGS = 16,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        cfg_valid_i,
    output logic                        cfg_ready_o,
    input  logic                        cfg_last_i,
    input  logic [ADDR_W-1:0]           cfg_addr_i,
    input  logic [$clog2(DATA_W):0]     cfg_size_i,
    input  logic [1:0]                  cfg_access_i,
    input  logic [DATA_W-1:0]           cfg_reset_i,
    output logic                        cfg_err_o,
    output logic [$clog2(N_REGS+1)-1:0] cfg_count_o,
    output logic                        ready_o,
    input  logic                        reload_i,
`ifdef SVDB_REG_HW_SET_EN
    input  logic                        hw_set_valid_i,
    input  logic [$clog2(N_REGS)-1:0]   hw_set_idx_i,
    input  logic [DATA_W-1:0]           hw_set_data_i,
`endif
    input  logic                        bus_req_i,
    input  logic                        bus_we_i,
    input  logic [ADDR_W-1:0]           bus_addr_i,
    input  logic [DATA_W-1:0]           bus_wdata_i,
    output logic                        bus_rvalid_o,
    output logic [DATA_W-1:0]           bus_rdata_o,
    output logic                        bus_err_o
);

    // The descriptor struct is sized by the package widths, which match the default parameters
    localparam int CNT_W = $clog2(N_REGS + 1);
    localparam int IDX_W = $clog2(N_REGS);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               cfg_err_q, cfg_err_d;
    logic               rvalid_q, rvalid_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               err_q, err_d;
    reg_desc_t          desc_q [N_REGS];
    reg_desc_t          desc_d [N_REGS];
    logic [DATA_W-1:0]  val_q [N_REGS];
    logic [DATA_W-1:0]  val_d [N_REGS];

    logic [ADDR_W-1:0]              key;
    logic [N_REGS-1:0][ADDR_W-1:0]  entry_addr;
    logic [N_REGS-1:0]              entry_vld;
    logic                           hit;
    logic [IDX_W-1:0]               hit_idx;
    reg_desc_t                      new_desc;
    logic                           reject;
    logic [DATA_W-1:0]              wmask;

    // One comparator serves both phases: duplicate check while loading, bus lookup once active
    assign key = (state_q == LOAD) ? cfg_addr_i : bus_addr_i;

    // Entries are packed from index 0, so validity is simply index < count
    always_comb begin
        entry_addr = '0;
        entry_vld  = '0;
        for (int i = 0; i < N_REGS; i++) begin
            entry_addr[i] = desc_q[i].addr;
            entry_vld[i]  = (i < int'(count_q));
        end
    end

    svdb_reg_match #(
        .N      (N_REGS),
        .ADDR_W (ADDR_W),
        .IDX_W  (IDX_W)
    ) u_match (
        .key_i        (key),
        .entry_addr_i (entry_addr),
        .entry_vld_i  (entry_vld),
        .hit_o        (hit),
        .idx_o        (hit_idx)
    );

    // Next-state logic: descriptor loading, bus access policy, optional hardware set, reload
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        cfg_err_d = cfg_err_q;
        desc_d    = desc_q;
        val_d     = val_q;
        rvalid_d  = 1'b0;
        rdata_d   = '0;
        err_d     = 1'b0;

        new_desc.addr   = cfg_addr_i;
        new_desc.size   = cfg_size_i;
        new_desc.access = access_e'(cfg_access_i);
        new_desc.mask   = size_to_mask(cfg_size_i);

        reject = (cfg_size_i == '0) || (int'(cfg_size_i) > DATA_W) || hit
                 || (int'(count_q) == N_REGS);
        wmask  = bus_wdata_i & desc_q[hit_idx].mask;

        if (state_q == LOAD) begin
            if (reload_i) begin
                count_d   = '0;
                cfg_err_d = 1'b0;
            end else if (cfg_valid_i) begin
                if (reject) begin
                    cfg_err_d = 1'b1;
                end else begin
                    desc_d[count_q[IDX_W-1:0]] = new_desc;
                    val_d[count_q[IDX_W-1:0]]  = cfg_reset_i & new_desc.mask;
                    count_d                    = count_q + CNT_W'(1);
                end
                // A rejected final row still closes the table
                if (cfg_last_i) begin
                    state_d = ACTIVE;
                end
            end
            if (bus_req_i) begin
                rvalid_d = 1'b1;
                err_d    = 1'b1;
            end
        end else begin
            if (bus_req_i) begin
                rvalid_d = 1'b1;
                if (reload_i || !hit) begin
                    err_d = 1'b1;
                end else if (bus_we_i) begin
                    case (desc_q[hit_idx].access)
                        ACC_RO:         err_d = 1'b1;
                        ACC_RW, ACC_WO: val_d[hit_idx] = wmask;
                        ACC_W1C:        val_d[hit_idx] = val_q[hit_idx] & ~wmask;
                    endcase
                end else if (desc_q[hit_idx].access == ACC_WO) begin
                    err_d = 1'b1;
                end else begin
                    rdata_d = val_q[hit_idx];
                end
            end
`ifdef SVDB_REG_HW_SET_EN
            // Applied on top of any bus clear this cycle so freshly set bits survive
            if (hw_set_valid_i && !reload_i && (int'(hw_set_idx_i) < int'(count_q))
                && (desc_q[hw_set_idx_i].access == ACC_W1C)) begin
                val_d[hw_set_idx_i] = val_d[hw_set_idx_i]
                                      | (hw_set_data_i & desc_q[hw_set_idx_i].mask);
            end
`endif
            if (reload_i) begin
                state_d   = LOAD;
                count_d   = '0;
                cfg_err_d = 1'b0;
            end
        end
    end

    // Control state and bus response registers, cleared by reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= LOAD;
            count_q   <= '0;
            cfg_err_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            cfg_err_q <= cfg_err_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    // Descriptor and value storage; contents beyond count are never observed, so no reset
    always_ff @(posedge clk_i) begin
        desc_q <= desc_d;
        val_q  <= val_d;
    end

    assign cfg_ready_o  = (state_q == LOAD);
    assign ready_o      = (state_q == ACTIVE);
    assign cfg_err_o    = cfg_err_q;
    assign cfg_count_o  = count_q;
    assign bus_rvalid_o = rvalid_q;
    assign bus_rdata_o  = rdata_q;
    assign bus_err_o    = err_q;

endmodule

// File: doc/svdb_reg_bank.md
Name: svdb_reg_bank

Overview:
- Synthesizable register bank, configured at run time from register descriptors.
- Sits downstream of the DPI/SQLite register reader. The testbench iterates the `registers` table (addressOffset, size, access, resetValue) and streams one descriptor per row into the load port.
- After load, serves a simple single-beat bus. Applies per-register access policy, size masking and reset values.

Parameters:
- N_REGS, 16, maximum number of descriptors stored
- ADDR_W, 16, width of addressOffset and bus address
- DATA_W, 32, register/bus data width; size field range is 1..DATA_W

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- cfg_valid_i  in  1  descriptor valid
- cfg_ready_o  out  1  descriptor accepted when valid&ready
- cfg_last_i  in  1  final descriptor of the table
- cfg_addr_i  in  ADDR_W  addressOffset
- cfg_size_i  in  $clog2(DATA_W)+1  size in bits
- cfg_access_i  in  2  access code (svdb_reg_pkg)
- cfg_reset_i  in  DATA_W  resetValue
- cfg_err_o  out  1  sticky; duplicate address, overflow, or illegal size
- cfg_count_o  out  $clog2(N_REGS+1)  descriptors stored
- ready_o  out  1  bank ACTIVE
- reload_i  in  1  discard the table and return to LOAD
- bus_req_i  in  1  access request, single cycle
- bus_we_i  in  1  1=write
- bus_addr_i  in  ADDR_W  byte offset
- bus_wdata_i  in  DATA_W  write data
- bus_rvalid_o  out  1  response strobe
- bus_rdata_o  out  DATA_W  read data; 0 on error or write
- bus_err_o  out  1  miss, access violation, or not ACTIVE

Behaviour:
- Reset:
  - State LOAD; count 0; all entries invalid.
  - cfg_ready_o=1; cfg_err_o=0; ready_o=0.
  - bus_rvalid_o=0, bus_rdata_o=0, bus_err_o=0.
- FSM: LOAD -> ACTIVE when a beat with cfg_last_i is accepted. ACTIVE -> LOAD on reload_i, which clears entries, count and cfg_err_o on the next edge. reload_i in LOAD restarts the load.
- LOAD:
  - cfg_ready_o=1 always.
  - Each accepted beat is stored at index count, count++. The value is set to cfg_reset_i & mask, where mask = size==DATA_W ? all-ones : (1<<size)-1.
  - A rejected beat is not stored and sets cfg_err_o; count is unchanged. Reject causes: size 0, size >DATA_W, address equal to any stored entry, count==N_REGS.
  - A rejected beat carrying cfg_last still completes the load.
  - Zero entries after last is legal; every access then misses.
- ACTIVE:
  - cfg_ready_o=0.
  - Lookup compares bus_addr_i in parallel against all valid entries. Response is registered: bus_rvalid_o pulses exactly 1 cycle after bus_req_i.
  - Read: RO, RW and W1C return value. WO returns err=1, rdata=0.
  - Write, gated by policy:
    - RW and WO: value <= wdata & mask.
    - W1C: value <= value & ~(wdata & mask).
    - RO: err=1, value unchanged.
  - Miss: err=1, rdata=0, no state change.
- bus_req_i outside ACTIVE: response next cycle with err=1.
- Back-to-back requests each get a response; a read following a write to the same address sees the new value.
- reload_i and bus_req_i in the same cycle: the request is answered with err=1 and the write is not applied.
- Mid-operation reset overrides everything, including an in-flight response.

Optional Feature:
- Macro: SVDB_REG_HW_SET_EN.
- When defined:
  - Adds ports hw_set_valid_i (1), hw_set_idx_i ($clog2(N_REGS)), hw_set_data_i (DATA_W).
  - In ACTIVE, a valid set ORs hw_set_data_i & mask into entry hw_set_idx_i, only if that entry's access is W1C and idx < count; otherwise it is ignored.
  - Same cycle as a bus W1C write to the same entry: apply the clear first, then the set, so set bits survive.
- When undefined: the ports are absent and W1C bits change only by bus clears.

Decomposition:
- Package svdb_reg_pkg holds:
  - typedef access_e: ACC_RO=0, ACC_RW=1, ACC_WO=2, ACC_W1C=3.
  - typedef state_e {LOAD, ACTIVE}.
  - Descriptor struct reg_desc_t: addr, size, access, mask.
  - Function size_to_mask.
- One sub-module, svdb_reg_match: a parameterised parallel address comparator. It returns a hit flag and index, and is shared by the lookup and the duplicate check.

Test Plan:
- Load status_register (0x00, size 32, RO, reset 0xA5A5A5A5) and control_register (0x04, size 8, RW, reset 0x1FF) with last -> cfg_count_o=2, ready_o=1. Read 0x04 gives 0xFF, err=0. Write 0x04 with 0x12345678 -> read back 0x78.
- Write 0x00 (RO) -> err=1; a subsequent read returns 0xA5A5A5A5. Read unmapped 0x40 -> err=1, rdata=0. Response appears 1 cycle after the request.
- W1C status_flags at 0x08 with reset 0xF0 -> write 0x30, read 0xC0. WO control_bits at 0x0C -> read gives err=1.
- Duplicate address 0x04 during load -> cfg_err_o=1, count unchanged. N_REGS+1 descriptors -> last rejected, count=N_REGS.
- Bus request during LOAD -> err=1. reload_i in ACTIVE -> ready_o=0 and count 0. rst_i asserted mid-load -> all outputs return to reset values.
- With SVDB_REG_HW_SET_EN defined: hw_set idx 2, data 0x01 in the same cycle as a bus W1C write of 0xC1 to 0x08 (value 0xC1) -> read 0x01.
